// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_arbiter
//  Description : Shares one SRAM-like slave port between the IF-stage
//                instruction requester and the EXE-stage data requester.
//                Data has priority, a presented request stays granted until
//                the slave accepts it, and an owner FIFO steers each in-order
//                response back to the master that issued it.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_like_arbiter #(
  parameter int OUTSTD = 2            // max accepted-but-unanswered transactions (1..4)
) (
  input  logic        clk,
  input  logic        resetn,

  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  // shared slave port
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,

  // sticky protocol violation flag
  output logic        proto_err
);

  // --------------------------------------------------------------------------
  // Local sizing
  // --------------------------------------------------------------------------
  localparam int PTR_W = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
  localparam int CNT_W = $clog2(OUTSTD + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTD);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTD - 1);

  // Grant lock: IDLE arbitrates freely, the LOCK states pin the grant to the
  // master whose request is sitting on the slave port without addr_ok yet.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_state_t;

  lock_state_t state;
  lock_state_t state_nxt;

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic              sel_data;      // grant points at the data master
  logic              sel_inst;      // grant points at the instruction master
  logic              master_req;    // selected master is requesting
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;          // slave accepted a request this cycle
  logic              pop;           // slave answered an outstanding request
  logic              head_data;     // owner of the oldest outstanding entry

  logic [OUTSTD-1:0] owner;         // 1 = DATA, 0 = INST
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // Pointer increment that wraps at OUTSTD (depth need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + 1'b1;
    end
    return r;
  endfunction

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == CNT_ZERO);

  // --------------------------------------------------------------------------
  // Lock state register
  // --------------------------------------------------------------------------
  // Holds which master, if any, owns a stalled request on the slave port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant selection, slave request qualification and lock next-state.
  // sram_req is also masked by resetn so the slave sees nothing while the
  // arbiter is held in reset, whatever the masters happen to drive.
  always_comb begin
    state_nxt  = state;
    sel_data   = 1'b0;
    sel_inst   = 1'b0;

    case (state)
      ST_LOCK_INST: sel_inst = 1'b1;
      ST_LOCK_DATA: sel_data = 1'b1;
      default: begin
        sel_data = data_req;
        sel_inst = ~data_req & inst_req;
      end
    endcase

    master_req = (sel_data & data_req) | (sel_inst & inst_req);
    sram_req   = master_req & ~fifo_full & resetn;

    // A full FIFO drops sram_req, so the lock simply holds until room frees up
    if (sram_req) begin
      if (sram_addr_ok) begin
        state_nxt = ST_IDLE;
      end else if (sel_data) begin
        state_nxt = ST_LOCK_DATA;
      end else begin
        state_nxt = ST_LOCK_INST;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request payload mux
  // --------------------------------------------------------------------------
  // Data fields are the default so an idle port mirrors the data master.
  always_comb begin
    if (sel_inst) begin
      sram_wr    = inst_wr;
      sram_size  = inst_size;
      sram_addr  = inst_addr;
      sram_wstrb = inst_wstrb;
      sram_wdata = inst_wdata;
    end else begin
      sram_wr    = data_wr;
      sram_size  = data_size;
      sram_addr  = data_addr;
      sram_wstrb = data_wstrb;
      sram_wdata = data_wdata;
    end
  end

  // addr_ok passes straight through to the granted master only
  assign push         = sram_req & sram_addr_ok;
  assign data_addr_ok = push & sel_data;
  assign inst_addr_ok = push & sel_inst;

  // --------------------------------------------------------------------------
  // Owner FIFO
  // --------------------------------------------------------------------------
  assign pop       = sram_data_ok & ~fifo_empty;
  assign head_data = owner[rd_ptr];

  // Records the issuing master of every accepted request in acceptance order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        owner[wr_ptr] <= sel_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  // Read data is unregistered; only the data_ok strobe is steered.
  assign data_data_ok = pop & head_data;
  assign inst_data_ok = pop & ~head_data;
  assign data_rdata   = sram_rdata;
  assign inst_rdata   = sram_rdata;

  // Flags a response that arrives with nothing outstanding; sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (sram_data_ok & fifo_empty) begin
      proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_like_arbiter
//  Description : Self-checking bench for sram_like_arbiter: directed scenarios
//                followed by randomized master/slave traffic, all compared
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_like_arbiter;

  localparam int OUTSTD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTD(OUTSTD)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding owners in acceptance order (1 = DATA)
  bit q[$];
  bit m_lock, m_lock_data, m_perr;

  // Expectations computed for the current cycle
  bit x_sd, x_si, x_req, x_dacc, x_iacc, x_dok, x_iok;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lock      = 1'b0;
    m_lock_data = 1'b0;
    m_perr      = 1'b0;
  endtask

  // Compute this cycle's expected outputs from the rules and compare at negedge
  task automatic eval(input string tag);
    bit full, mreq;
    @(negedge clk);
    if (!resetn) model_reset();
    full = (q.size() == OUTSTD);
    if (m_lock) begin
      x_sd = m_lock_data;
      x_si = !m_lock_data;
    end else begin
      x_sd = data_req;
      x_si = !data_req && inst_req;
    end
    mreq   = (x_sd && data_req) || (x_si && inst_req);
    x_req  = mreq && !full && (resetn === 1'b1);
    x_dacc = x_req && sram_addr_ok && x_sd;
    x_iacc = x_req && sram_addr_ok && x_si;
    x_dok  = sram_data_ok && (q.size() > 0) && q[0];
    x_iok  = sram_data_ok && (q.size() > 0) && !q[0];

    chk({tag, ".sram_req"}, sram_req, x_req);
    chk({tag, ".payload"}, {sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata},
        x_si ? {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata}
             : {data_wr, data_size, data_addr, data_wstrb, data_wdata});
    chk({tag, ".data_addr_ok"}, data_addr_ok, x_dacc);
    chk({tag, ".inst_addr_ok"}, inst_addr_ok, x_iacc);
    chk({tag, ".data_data_ok"}, data_data_ok, x_dok);
    chk({tag, ".inst_data_ok"}, inst_data_ok, x_iok);
    chk({tag, ".proto_err"}, proto_err, m_perr);
    if (x_dok) chk({tag, ".data_rdata"}, data_rdata, sram_rdata);
    if (x_iok) chk({tag, ".inst_rdata"}, inst_rdata, sram_rdata);
  endtask

  // Apply the clock edge to the model, then step past the edge
  task automatic adv();
    bit had;
    if (resetn === 1'b1) begin
      had = (q.size() > 0);
      if (sram_data_ok) begin
        if (had) q.delete(0);
        else     m_perr = 1'b1;
      end
      if (x_req) begin
        if (sram_addr_ok) begin
          q.push_back(x_sd);
          m_lock = 1'b0;
        end else begin
          m_lock      = 1'b1;
          m_lock_data = x_sd;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = '0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h0000_1000;
    inst_wstrb = 4'hf; inst_wdata = 32'h1111_0000;
    data_req = 0; data_wr = 1; data_size = 2'd1; data_addr = 32'h8000_2000;
    data_wstrb = 4'h3; data_wdata = 32'h2222_0000;
    sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = '0;
    model_reset();

    // Reset state
    eval("rst"); adv();
    eval("rst2");
    chk("rst.sram_req_zero", sram_req, 1'b0);
    chk("rst.proto_err_zero", proto_err, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Both request together: data wins
    inst_req = 1; data_req = 1; sram_addr_ok = 1;
    eval("t1");
    chk("t1.data_wins", data_addr_ok, 1'b1);
    chk("t1.inst_loses", inst_addr_ok, 1'b0);
    chk("t1.addr_is_data", sram_addr, 32'h8000_2000);
    adv();
    idle_inputs();
    sram_data_ok = 1; sram_rdata = 32'hAAAA_5555;
    eval("t1r"); chk("t1r.data_ok", data_data_ok, 1'b1); adv();

    // Stalled inst request is not pre-empted by a later data request
    idle_inputs(); inst_req = 1; inst_addr = 32'h0000_1004;
    eval("t2a"); adv();
    data_req = 1;
    eval("t2b"); chk("t2b.addr_held", sram_addr, 32'h0000_1004); adv();
    eval("t2c"); chk("t2c.addr_held", sram_addr, 32'h0000_1004); adv();
    sram_addr_ok = 1;
    eval("t2d"); chk("t2d.inst_acc", inst_addr_ok, 1'b1); chk("t2d.data_wait", data_addr_ok, 1'b0); adv();
    inst_req = 0;
    eval("t2e"); chk("t2e.data_acc", data_addr_ok, 1'b1); adv();
    idle_inputs(); sram_data_ok = 1; sram_rdata = 32'h0BAD_F00D;
    eval("t2f"); chk("t2f.inst_ok", inst_data_ok, 1'b1); adv();
    sram_rdata = 32'h600D_CAFE;
    eval("t2g"); chk("t2g.data_ok", data_data_ok, 1'b1); adv();

    // Fill to OUTSTD, blocked third request, in-order response
    idle_inputs(); inst_req = 1; sram_addr_ok = 1; inst_addr = 32'h0000_1008;
    eval("t3a"); adv();
    inst_req = 0; data_req = 1;
    eval("t3b"); adv();
    data_req = 0; inst_req = 1; inst_addr = 32'h0000_100C;
    eval("t3c"); chk("t3c.full_req", sram_req, 1'b0); chk("t3c.full_aok", inst_addr_ok, 1'b0); adv();
    sram_data_ok = 1; sram_rdata = 32'h1234_5678;
    eval("t3d");
    chk("t3d.inst_ok", inst_data_ok, 1'b1);
    chk("t3d.inst_rdata", inst_rdata, 32'h1234_5678);
    adv();

    // Push and pop in the same cycle with one entry outstanding
    sram_rdata = 32'h0000_CAFE;
    eval("t4a");
    chk("t4a.inst_acc", inst_addr_ok, 1'b1);
    chk("t4a.data_ok", data_data_ok, 1'b1);
    adv();
    inst_req = 0; sram_rdata = 32'h0000_BEEF;
    eval("t4b"); chk("t4b.inst_ok", inst_data_ok, 1'b1); chk("t4b.no_data_ok", data_data_ok, 1'b0); adv();

    // Response with nothing outstanding
    idle_inputs(); sram_data_ok = 1; sram_rdata = 32'hDEAD_0000;
    eval("t5a"); chk("t5a.no_dok", data_data_ok, 1'b0); chk("t5a.no_iok", inst_data_ok, 1'b0); adv();
    sram_data_ok = 0;
    eval("t5b"); chk("t5b.perr", proto_err, 1'b1); adv();
    eval("t5c"); chk("t5c.perr_sticky", proto_err, 1'b1); adv();

    // Asynchronous reset while full
    data_req = 1; sram_addr_ok = 1;
    eval("t6a"); adv();
    eval("t6b"); adv();
    data_req = 0; inst_req = 1;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("t6.async_perr", proto_err, 1'b0);
    chk("t6.async_req", sram_req, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1; inst_req = 0; data_req = 1;
    eval("t6c"); chk("t6c.acc", data_addr_ok, 1'b1); adv();
    eval("t6d"); chk("t6d.acc_after_clear", data_addr_ok, 1'b1); adv();
    idle_inputs(); sram_data_ok = 1;
    eval("t6e"); adv();
    eval("t6f"); adv();

    // Asynchronous reset clears a held lock
    idle_inputs(); inst_req = 1; inst_addr = 32'h0000_2000;
    eval("t7a"); adv();
    data_req = 1;
    #2 resetn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1; sram_addr_ok = 1;
    eval("t7b"); chk("t7b.lock_gone", sram_addr, 32'h8000_2000); chk("t7b.data_acc", data_addr_ok, 1'b1); adv();
    idle_inputs(); sram_data_ok = 1;
    eval("t7c"); adv();
    idle_inputs();

    // Randomized traffic; masters hold a request until it is accepted
    for (int i = 0; i < 600; i++) begin
      if (!(inst_req && !x_iacc)) begin
        inst_req   = ($urandom_range(0, 2) != 0);
        inst_wr    = 1'($urandom);
        inst_size  = 2'($urandom_range(0, 3));
        inst_addr  = $urandom;
        inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
      end
      if (!(data_req && !x_dacc)) begin
        data_req   = ($urandom_range(0, 2) == 0);
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom_range(0, 3));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      sram_addr_ok = 1'($urandom);
      sram_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      sram_rdata   = $urandom;
      eval("rnd");
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
